// File: rtl/uaz8_data_bus_arbiter.sv
// Two-requester (core / loader) round-robin arbiter for the microUAZ8 data bus.
// Latency: grant one cycle after a request is first seen in IDLE; seamless handoff; read data registered +1 cycle.
// Backpressure: core is stalled (core_stall) and loader is un-acked while the other side owns the bus.
// Optional feature: define UAZ8_ARB_STALL_CNT_EN to build the saturating core stall-cycle counter.
module uaz8_data_bus_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  // core side
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  // loader / debug side
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] ld_rdata,
  // data memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_le,
  input  logic [DW-1:0] mem_rdata,
  // diagnostics
  output logic [7:0]    stall_cnt
);

  // Burst limit as a 4-bit quantity (legal range 1..15).
  localparam logic [3:0] MB     = MAX_BURST[3:0];
  localparam logic [4:0] MB_EXT = {1'b0, MB};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_LDR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      bcnt_q, bcnt_d;
  // Owner most recently left: 0 = core, 1 = loader.
  logic            last_q, last_d;
  logic [DW-1:0]   core_rdata_q;
  logic [DW-1:0]   ld_rdata_q;

  logic            core_acc;
  logic            ld_acc;
  logic            burst_done;
  logic [3:0]      bcnt_inc;

  // An access only happens when the owner is actually requesting and we are out of reset.
  assign core_acc = (state_q == ST_CORE) & core_req & Rst;
  assign ld_acc   = (state_q == ST_LDR)  & ld_req   & Rst;

  // The access in flight this cycle is the MAX_BURST-th (or later) of this tenure.
  assign burst_done = (({1'b0, bcnt_q} + 5'd1) >= MB_EXT);
  assign bcnt_inc   = (bcnt_q >= MB) ? MB : (bcnt_q + 4'd1);

  // Next owner, burst count and last-owner bookkeeping.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req && ld_req) begin
          // Tie goes to the side that did not own the bus last.
          state_d = last_q ? ST_CORE : ST_LDR;
        end else if (core_req) begin
          state_d = ST_CORE;
        end else if (ld_req) begin
          state_d = ST_LDR;
        end
      end
      ST_CORE: begin
        if (!core_req) begin
          state_d = ld_req ? ST_LDR : ST_IDLE;
        end else begin
          bcnt_d = bcnt_inc;
          if (burst_done && ld_req) begin
            state_d = ST_LDR;
          end
        end
      end
      ST_LDR: begin
        if (!ld_req) begin
          state_d = core_req ? ST_CORE : ST_IDLE;
        end else begin
          bcnt_d = bcnt_inc;
          if (burst_done && core_req) begin
            state_d = ST_CORE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Any ownership change starts a fresh burst and remembers who was left.
    if (state_d != state_q) begin
      bcnt_d = 4'd0;
      if (state_q == ST_CORE) begin
        last_d = 1'b0;
      end else if (state_q == ST_LDR) begin
        last_d = 1'b1;
      end
    end
  end

  // Arbitration state register; core wins the first tie after reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      last_q  <= last_d;
    end
  end

  // Read data is latched on the owner's access cycle and held otherwise.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      core_rdata_q <= '0;
      ld_rdata_q   <= '0;
    end else begin
      if (core_acc) begin
        core_rdata_q <= mem_rdata;
      end
      if (ld_acc) begin
        ld_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory bus mux: owner's signals, all zero in IDLE and while reset is low.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_le    = 1'b0;
    if (Rst) begin
      case (state_q)
        ST_CORE: begin
          mem_addr  = core_addr;
          mem_wdata = core_wdata;
          mem_le    = core_we & core_req;
        end
        ST_LDR: begin
          mem_addr  = ld_addr;
          mem_wdata = ld_wdata;
          mem_le    = ld_we & ld_req;
        end
        default: begin
          mem_addr  = '0;
          mem_wdata = '0;
          mem_le    = 1'b0;
        end
      endcase
    end
  end

  assign ld_ack     = ld_acc;
  // Stall is deliberately not gated by reset: the core must hold during reset too.
  assign core_stall = core_req & (state_q != ST_CORE);
  assign core_rdata = core_rdata_q;
  assign ld_rdata   = ld_rdata_q;

`ifdef UAZ8_ARB_STALL_CNT_EN
  logic [7:0] stall_cnt_q;

  // Saturating count of cycles the core spent stalled since reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_q <= 8'h00;
    end else if (core_stall && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_q <= stall_cnt_q + 8'h01;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 8'h00;
`endif

endmodule

// File: doc/uaz8_data_bus_arbiter.md
# uaz8_data_bus_arbiter

Two-requester arbiter for the 8-bit data memory bus of the microUAZ8 core. It shares the single data bus (address, write data, LE, read data) between the processor core and an external loader/debug port. Arbitration is round-robin with a burst limit, and the core is stalled while the bus is owned by the loader. It sits between the core's output-control stage and the data memory.

## Interface
- `AW`, default 8: data address width.
- `DW`, default 8: data width.
- `MAX_BURST`, default 4: maximum consecutive granted accesses per owner while the other side is requesting; range 1..15.

Ports:
- `Clk`  in  1  single clock; everything is on the rising edge.
- `Rst`  in  1  synchronous reset, active-low.
- `core_req`  in  1  core requests a data access this cycle.
- `core_we`  in  1  core access is a write (core LE).
- `core_addr`  in  AW  core data address.
- `core_wdata`  in  DW  core write data.
- `core_rdata`  out  DW  registered read data returned to the core.
- `core_stall`  out  1  core must hold its request and freeze.
- `ld_req`  in  1  loader requests an access.
- `ld_we`  in  1  loader access is a write.
- `ld_addr`  in  AW  loader address.
- `ld_wdata`  in  DW  loader write data.
- `ld_ack`  out  1  loader access is performed this cycle.
- `ld_rdata`  out  DW  registered read data returned to the loader.
- `mem_addr`  out  AW  address to data memory.
- `mem_wdata`  out  DW  write data to data memory.
- `mem_le`  out  1  memory write/latch enable.
- `mem_rdata`  in  DW  combinational read data from memory.
- `stall_cnt`  out  8  core stall-cycle counter; see Configuration.

## Operation
- Registered states: IDLE, CORE, LDR. A 4-bit burst counter `bcnt` and a `last` owner bit (0 = core, 1 = loader) are also registered.
- From IDLE:
  - Only one side requests: go to that side's state.
  - Both request: go to the side opposite `last`.
  - Neither requests: stay in IDLE.
- In an owner state with the owner's request high, one access is performed every cycle. `bcnt` increments and saturates at `MAX_BURST`.
- Leaving an owner state:
  - The owner's request drops: go to the other state if it is requesting, else IDLE.
  - `bcnt` reaches `MAX_BURST` and the other side is requesting: go to the other state after the current access.
  - There is no idle bubble on a handoff.
- On every state change, `bcnt` clears to 0 and `last` is updated to the owner being left.
- Memory bus drive:
  - Driven from the owner's signals in CORE and LDR.
  - Forced to 0 in IDLE.
  - `mem_le` equals the owner's `we` ANDed with the owner's `req` ANDed with `Rst`.
- `ld_ack` = (state == LDR) & `ld_req` & `Rst`.
- `core_stall` = `core_req` & (state != CORE). It is combinational and also asserted during reset.
- `core_rdata` and `ld_rdata` capture `mem_rdata` on the owner's access cycle. They hold their value otherwise.

## Timing
- Grant latency: a request first seen in IDLE at cycle N gives its first access at N+1.
- Handoff: the other side's first access is in the cycle immediately after the releasing owner's last access.
- Read data is valid one cycle after the access (ack) cycle.
- A write is committed on the edge that ends the `mem_le` cycle.
- Reset values, while `Rst` is low and on the following edge:
  - state = IDLE, `bcnt` = 0, `last` = 1 (so the core wins the first tie).
  - `core_rdata`, `ld_rdata` and `stall_cnt` = 0.
  - `mem_*` = 0; `mem_le` and `ld_ack` = 0.
- Reset mid-burst: the access in the reset cycle is suppressed (no `mem_le`, no `ld_ack`). The burst restarts from IDLE.
- `MAX_BURST` = 1: ownership strictly alternates every access under continuous dual request.
- A request dropping mid-burst is legal. Re-raising it re-enters arbitration under the normal rules.

## Configuration
- `UAZ8_ARB_STALL_CNT_EN` defined:
  - `stall_cnt` increments every cycle with `core_stall` = 1.
  - It saturates at 8'hFF and clears only on reset.
- Undefined: `stall_cnt` is tied to 8'h00 and no counter logic is built.

## Test plan
- Core only. `core_req` = 1, write 0x5A to address 0x10 on cycle 1 -> state CORE at cycle 1, `mem_le` = 1 with `mem_addr` = 0x10, `mem_wdata` = 0x5A, `core_stall` = 0 from cycle 1.
- Loader read. `ld_req` = 1, `ld_addr` = 0x20, memory returns 0xC3 -> `ld_ack` 1 cycle after the request, `ld_rdata` = 0xC3 one cycle after the ack.
- Tie after reset. Both request on the first cycle out of reset -> core granted first. With `MAX_BURST` = 4, the core does 4 accesses, the loader does 4, then the core again; no idle cycle between owners.
- Starvation bound. The loader requests continuously and the core raises `core_req` -> `core_stall` stays high at most `MAX_BURST` cycles. With the macro on, `stall_cnt` equals the measured stall cycles (e.g. 4).
- Reset mid-burst. Drop `Rst` during the loader's 2nd write -> no `mem_le` in that cycle, state IDLE after the edge, all outputs at their reset values.
- `MAX_BURST` = 1 build. Continuous dual request -> `ld_ack` is high every other cycle; `core_stall` alternates with it.
